// File: rtl/mips_pipe_pkg.sv
// ============================================================================
// Module  : mips_pipe_pkg
// Brief   : Shared constants for the MIPS pipeline hazard/stall controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pipe_pkg;

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_FREEZE   = 2'd1;
    localparam logic [1:0] c_ERROR    = 2'd2;

    localparam logic [4:0] c_REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : W-bit up counter that holds at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : Load-use stall, branch flush and memory-freeze sequencing for the
//           5-stage MIPS pipe, with saturating debug counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             exmem_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [TO_W-1:0] r_tcnt;
    logic [TO_W-1:0] w_tcnt_next;

    logic w_load_use;
    logic w_mem_wait;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_freeze_inc;

    // A load into $zero never produces a value, so it cannot cause a hazard.
    assign w_load_use = idex_mem_read && (idex_rt != c_REG_ZERO) &&
                        ((id_uses_rs && (idex_rt == ifid_rs)) ||
                         (id_uses_rt && (idex_rt == ifid_rt)));
    assign w_mem_wait = exmem_mem_req && !dmem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_RUN;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_tcnt  <= w_tcnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tcnt_next  = r_tcnt;
        case (r_state)
            c_RUN: begin
                if (w_mem_wait) begin
                    w_next_state = c_FREEZE;
                    w_tcnt_next  = TO_W'(1);
                end
            end
            c_FREEZE: begin
                if (dmem_ready) begin
                    w_next_state = c_RUN;
                    w_tcnt_next  = '0;
                end else begin
                    w_tcnt_next = r_tcnt + TO_W'(1);
                    if (w_tcnt_next >= TO_W'(MEM_TIMEOUT)) begin
                        w_next_state = c_ERROR;
                    end
                end
            end
            c_ERROR: begin
                w_next_state = c_ERROR;
            end
            default: begin
                w_next_state = c_RUN;
                w_tcnt_next  = '0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        freeze       = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_freeze_inc = 1'b0;
        if (reset) begin
            idex_bubble = 1'b1;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (w_mem_wait) begin
                        freeze       = 1'b1;
                        w_freeze_inc = 1'b1;
                    end else if (w_load_use) begin
                        idex_bubble = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (id_branch_taken || id_jump) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        w_flush_inc = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                c_FREEZE: begin
                    freeze       = 1'b1;
                    w_freeze_inc = 1'b1;
                end
                c_ERROR: begin
                    freeze = 1'b1;
                end
                default: begin
                    freeze = 1'b1;
                end
            endcase
        end
    end

    assign mem_error = (r_state == c_ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_freeze_inc),
        .count (freeze_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed-vector scoreboard bench for hazard_stall_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          id_uses_rs, id_uses_rt, idex_mem_read;
    logic          id_branch_taken, id_jump, exmem_mem_req, dmem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, freeze, mem_error;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock           (clk),
        .reset           (rst),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .exmem_mem_req   (exmem_mem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .freeze          (freeze),
        .mem_error       (mem_error),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .freeze_cnt      (freeze_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   vec;
        logic pc, ifw, fl, bub, frz, err;
        int   sc, fc, zc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;

    task automatic chk(input int vec, input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL vec %0d %s actual=%0d required=%0d", vec, nm, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.vec, "pc_write",    int'(pc_write),    int'(e.pc));
                chk(e.vec, "ifid_write",  int'(ifid_write),  int'(e.ifw));
                chk(e.vec, "ifid_flush",  int'(ifid_flush),  int'(e.fl));
                chk(e.vec, "idex_bubble", int'(idex_bubble), int'(e.bub));
                chk(e.vec, "freeze",      int'(freeze),      int'(e.frz));
                chk(e.vec, "mem_error",   int'(mem_error),   int'(e.err));
                chk(e.vec, "stall_cnt",   int'(stall_cnt),   e.sc);
                chk(e.vec, "flush_cnt",   int'(flush_cnt),   e.fc);
                chk(e.vec, "freeze_cnt",  int'(freeze_cnt),  e.zc);
            end
        end
    end

    task automatic cyc(input logic pc, ifw, fl, bub, frz, err, input int sc, fc, zc);
        exp_t e;
        e.vec = vec_no; e.pc = pc; e.ifw = ifw; e.fl = fl; e.bub = bub;
        e.frz = frz; e.err = err; e.sc = sc; e.fc = fc; e.zc = zc;
        vec_no++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_run(input int sc, fc, zc);   cyc(1, 1, 0, 0, 0, 0, sc, fc, zc); endtask
    task automatic exp_stall(input int sc, fc, zc); cyc(0, 0, 0, 1, 0, 0, sc, fc, zc); endtask
    task automatic exp_flush(input int sc, fc, zc); cyc(1, 1, 1, 0, 0, 0, sc, fc, zc); endtask
    task automatic exp_frz(input int sc, fc, zc);   cyc(0, 0, 0, 0, 1, 0, sc, fc, zc); endtask
    task automatic exp_err(input int sc, fc, zc);   cyc(0, 0, 0, 0, 1, 1, sc, fc, zc); endtask
    task automatic exp_rst();                       cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);    endtask

    task automatic idle_in();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; idex_mem_read = 1'b0;
        id_branch_taken = 1'b0; id_jump = 1'b0;
        exmem_mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic lu_in();
        idle_in();
        idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        exp_rst();
        rst = 1'b0;
        idle_in();          exp_run(0, 0, 0);
        lu_in();            exp_stall(0, 0, 0);
        idle_in();          exp_run(1, 0, 0);
        idle_in(); idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; id_uses_rt = 1'b1;
                            exp_stall(1, 0, 0);
        id_uses_rt = 1'b0;  exp_run(2, 0, 0);
        lu_in(); idex_rt = 5'd0; ifid_rs = 5'd0;
                            exp_run(2, 0, 0);
        lu_in(); idex_mem_read = 1'b0;
                            exp_run(2, 0, 0);
        idle_in(); id_branch_taken = 1'b1; exp_flush(2, 0, 0);
        idle_in(); id_jump = 1'b1;         exp_flush(2, 1, 0);
        lu_in(); id_branch_taken = 1'b1;   exp_stall(2, 2, 0);
        idle_in();          exp_run(3, 2, 0);
        // Freeze with a pending load-use and branch: memory wait dominates.
        lu_in(); id_branch_taken = 1'b1; exmem_mem_req = 1'b1;
                            exp_frz(3, 2, 0);
        idle_in(); exmem_mem_req = 1'b1;
                            exp_frz(3, 2, 1);
                            exp_frz(3, 2, 2);
        dmem_ready = 1'b1;  exp_frz(3, 2, 3);
        idle_in();          exp_run(3, 2, 4);
        exmem_mem_req = 1'b1; dmem_ready = 1'b1;
                            exp_run(3, 2, 4);
        dmem_ready = 1'b0;  exp_frz(3, 2, 4);
                            exp_frz(3, 2, 5);
                            exp_frz(3, 2, 6);
                            exp_frz(3, 2, 7);
                            exp_err(3, 2, 7);
        idle_in(); dmem_ready = 1'b1; id_branch_taken = 1'b1;
                            exp_err(3, 2, 7);
        rst = 1'b1;         exp_rst();
        rst = 1'b0; idle_in();
                            exp_run(0, 0, 0);
        lu_in();
        for (int k = 0; k < 9; k++) begin
            exp_stall((k > 7) ? 7 : k, 0, 0);
        end
        idle_in();          exp_run(7, 0, 0);
        exmem_mem_req = 1'b1;
                            exp_frz(7, 0, 0);
                            exp_frz(7, 0, 1);
        rst = 1'b1;         exp_rst();
        rst = 1'b0; idle_in();
                            exp_run(0, 0, 0);
        id_branch_taken = 1'b1;
                            exp_flush(0, 0, 0);
        idle_in();          exp_run(0, 1, 0);
        @(negedge clk);
        #1;
        chk(vec_no, "queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
